// File: rtl/muldiv_seq_32.sv
// muldiv_seq_32: multi-cycle unsigned multu/divu sequencer sharing one ripple adder
module fa_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [32:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < 32; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[32];
endmodule

module muldiv_seq_32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic        op_r;
    logic [5:0]  cnt;
    logic [32:0] acc;
    logic [31:0] q;
    logic [31:0] m;
    logic [32:0] r_sh;
    logic [32:0] mul_sum;
    logic [31:0] add_a, add_b, add_s;
    logic        add_ci, add_co, take;
    logic [32:0] acc_nxt;
    logic [31:0] q_nxt;

    fa_32 u_add (.a(add_a), .b(add_b), .cin(add_ci), .sum(add_s), .cout(add_co));

    assign busy = state != IDLE;
    assign done = state == DONE;

    // One iteration: shift-add for multu, shift-then-trial-subtract for divu
    always_comb begin
        r_sh    = {acc[31:0], q[31]};
        add_a   = op_r ? r_sh[31:0] : acc[31:0];
        add_b   = op_r ? ~m : m;
        add_ci  = op_r;
        take    = r_sh[32] | add_co;
        mul_sum = q[0] ? {add_co, add_s} : {1'b0, acc[31:0]};
        acc_nxt = op_r ? (take ? {1'b0, add_s} : r_sh) : {1'b0, mul_sum[32:1]};
        q_nxt   = op_r ? {q[30:0], take} : {mul_sum[0], q[31:1]};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: fixed 32 iterations then a single DONE cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = (cnt == 6'd31) ? DONE : RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Working registers load on accept, iterate in RUN; outputs update on the last iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r <= 1'b0;
            cnt  <= 6'd0;
            acc  <= 33'd0;
            q    <= 32'd0;
            m    <= 32'd0;
            hi   <= 32'd0;
            lo   <= 32'd0;
        end else if (state == IDLE && start) begin
            op_r <= op;
            cnt  <= 6'd0;
            acc  <= 33'd0;
            q    <= op ? a : b;
            m    <= op ? b : a;
        end else if (state == RUN) begin
            acc <= acc_nxt;
            q   <= q_nxt;
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) begin
                hi <= acc_nxt[31:0];
                lo <= q_nxt;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_seq_32.sv
// tb_muldiv_seq_32: directed and random checks of muldiv_seq_32 against an arithmetic model
module tb_muldiv_seq_32;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;

    muldiv_seq_32 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] eh, output logic [31:0] el);
        logic [63:0] p;
        p = 64'(x) * 64'(y);
        if (!o)            begin eh = p[63:32]; el = p[31:0]; end
        else if (y == 0)   begin eh = x; el = 32'hFFFF_FFFF; end
        else               begin eh = x % y; el = x / y; end
    endtask

    // Issues one op (called #1 after a rising edge, DUT idle) and checks latency, result and handshake
    task automatic run_op(input string tag, input logic o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] eh, el;
        int cyc;
        logic bad;
        model(o, x, y, eh, el);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom;
        chk({tag, "_busy_accept"}, 32'(busy), 32'd1);
        cyc = 0;
        bad = 1'b0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (!busy) bad = 1'b1;
            if (!done && (hi !== eh || lo !== el) && cyc < 32) ; 
        end while (!done && cyc < 40);
        chk({tag, "_edges_to_done"}, 32'(cyc), 32'd32);
        chk({tag, "_busy_run"}, 32'(bad), 32'd0);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc, npulse;
        logic hold_bad;
        logic [31:0] ph, pl;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mul_max_hi_const", hi, 32'hFFFF_FFFE);
        chk("mul_max_lo_const", lo, 32'h0000_0001);
        run_op("div_100_7", 1'b1, 32'd100, 32'd7);
        chk("div_100_7_q", lo, 32'd14);
        chk("div_100_7_r", hi, 32'd2);
        run_op("div_msb_3", 1'b1, 32'h8000_0000, 32'd3);
        chk("div_msb_3_q", lo, 32'h2AAA_AAAA);
        chk("div_msb_3_r", hi, 32'd2);
        run_op("div_zero", 1'b1, 32'h1234_5678, 32'd0);
        chk("div_zero_q", lo, 32'hFFFF_FFFF);
        chk("div_zero_r", hi, 32'h1234_5678);

        // Second start during RUN must be ignored
        start = 1'b1; op = 1'b0; a = 32'd6; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        ph = hi; pl = lo;
        hold_bad = 1'b0;
        cyc = 0;
        do begin
            if (cyc == 9) begin start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd3; end
            if (cyc == 10) start = 1'b0;
            @(posedge clk); #1;
            cyc++;
            if (!done && (hi !== ph || lo !== pl)) hold_bad = 1'b1;
        end while (!done && cyc < 40);
        start = 1'b0;
        chk("ign_edges_to_done", 32'(cyc), 32'd32);
        chk("ign_hold_during_run", 32'(hold_bad), 32'd0);
        chk("ign_hi", hi, 32'd0);
        chk("ign_lo", lo, 32'd42);
        npulse = 0;
        hold_bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) npulse++;
            if (busy || hi !== 32'd0 || lo !== 32'd42) hold_bad = 1'b1;
        end
        chk("ign_no_second_done", 32'(npulse), 32'd0);
        chk("ign_idle_hold", 32'(hold_bad), 32'd0);

        // Asynchronous reset in the middle of RUN
        start = 1'b1; op = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst_3x5", 1'b0, 32'd3, 32'd5);
        chk("post_rst_lo", lo, 32'd15);
        chk("post_rst_hi", hi, 32'd0);

        // Random regression with a mix of small, boundary and full-range operands
        for (int i = 0; i < 300; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 4))
                0: y = y & 32'hFF;
                1: y = 32'd0;
                2: x = x & 32'hFFFF;
                default: ;
            endcase
            run_op("rand", 1'($urandom), x, y);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
